// File: rtl/axi_math_pkg.sv
// Width helpers shared by the AXI leaf blocks.
package axi_math_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int next_pow2(input int n);
    return (n <= 1) ? 1 : (1 << $clog2(n));
  endfunction

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI response encoding.
package axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_regfile.sv
// Register bank: one byte-strobed write port, one combinational read port,
// and the flattened contents for software-visible taps.
module axi_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (i_widx == IDX_W'(k)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (i_wstrb[b]) r_mem[k][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Explicit mux keeps indices beyond NUM_REGS-1 well defined (they read 0).
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_ridx == IDX_W'(k)) o_rdata = r_mem[k];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite leaf target: independent AW/W capture, one outstanding B and R,
// out-of-range accesses answered with SLVERR.
module axi_lite_reg_slave
  import axi_pkg::*;
  import axi_math_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  // Handshakes: a transfer happens on an edge where valid && ready are both
  // high; once a response is valid it is held unchanged until its ready.
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid, r_rvalid;
  axi_resp_t             r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic                  w_wr_hit, w_rd_hit;
  logic [ADDR_WIDTH-1:0] w_waddr, w_woff, w_wword, w_roff, w_rword;
  logic [DATA_WIDTH-1:0] w_wdata, w_rf_rdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_widx, w_ridx;

  assign awready_o = !rst_i && !r_aw_held && !r_bvalid;
  assign wready_o  = !rst_i && !r_w_held && !r_bvalid;
  assign arready_o = !rst_i && !r_rvalid;

  assign w_aw_hs  = awvalid_i && awready_o;
  assign w_w_hs   = wvalid_i && wready_o;
  assign w_ar_hs  = arvalid_i && arready_o;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // Same-cycle handshakes bypass the holding registers.
  assign w_waddr = r_aw_held ? r_awaddr : awaddr_i;
  assign w_wdata = r_w_held ? r_wdata : wdata_i;
  assign w_wstrb = r_w_held ? r_wstrb : wstrb_i;

  assign w_woff   = w_waddr - BASE_ADDR;
  assign w_wword  = w_woff >> BYTE_SHIFT;
  assign w_wr_hit = (w_waddr >= BASE_ADDR) && (w_wword < NUM_REGS_A);
  assign w_widx   = w_wword[IDX_W-1:0];

  assign w_roff   = araddr_i - BASE_ADDR;
  assign w_rword  = w_roff >> BYTE_SHIFT;
  assign w_rd_hit = (araddr_i >= BASE_ADDR) && (w_rword < NUM_REGS_A);
  assign w_ridx   = w_rword[IDX_W-1:0];

  axi_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_we    (w_commit && w_wr_hit),
    .i_widx  (w_widx),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .i_ridx  (w_ridx),
    .o_rdata (w_rf_rdata),
    .o_regs  (regs_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr_i;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata_i;
        r_wstrb  <= wstrb_i;
      end
      if (r_bvalid && bready_i) r_bvalid <= 1'b0;
    end
  end

  // Read samples the bank before any same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
      r_rdata  <= w_rd_hit ? w_rf_rdata : '0;
    end else if (r_rvalid && rready_i) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bvalid_o = r_bvalid;
  assign bresp_o  = r_bresp;
  assign rvalid_o = r_rvalid;
  assign rresp_o  = r_rresp;
  assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave (5 registers at base 0x100) with a
// transaction-level reference model compared every cycle.
module tb_axi_lite_reg_slave;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 5;
  localparam logic [31:0] BASE = 32'h100;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [AW-1:0]   awaddr_i;
  logic            awvalid_i;
  logic            awready_o;
  logic [DW-1:0]   wdata_i;
  logic [3:0]      wstrb_i;
  logic            wvalid_i;
  logic            wready_o;
  logic [1:0]      bresp_o;
  logic            bvalid_o;
  logic            bready_i;
  logic [AW-1:0]   araddr_i;
  logic            arvalid_i;
  logic            arready_o;
  logic [DW-1:0]   rdata_o;
  logic [1:0]      rresp_o;
  logic            rvalid_o;
  logic            rready_i;
  logic [NR*DW-1:0] regs_o;

  axi_lite_reg_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .araddr_i  (araddr_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .regs_o    (regs_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s actual=timeout expected=handshake at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_regs [NR];
  logic [31:0] m_aw_q [$];
  logic [35:0] m_w_q  [$];
  logic [1:0]  b_q    [$];
  logic [33:0] exp_q  [$];
  bit          model_live = 1'b0;

  function automatic bit decode(input logic [31:0] a, output int idx);
    longint off;
    off = longint'(a) - longint'(BASE);
    idx = int'(off / 4);
    return (off >= 0) && (idx < NR);
  endfunction

  initial begin : compare
    bit          e_awr, e_wr, e_arr, hit;
    int          idx;
    logic [31:0] a;
    logic [35:0] w;
    forever begin
      @(negedge clk_i);
      e_awr = !rst_i && (m_aw_q.size() == 0) && (b_q.size() == 0);
      e_wr  = !rst_i && (m_w_q.size() == 0) && (b_q.size() == 0);
      e_arr = !rst_i && (exp_q.size() == 0);
      if (model_live) begin
        for (int k = 0; k < NR; k++) check("regs_o", regs_o[k*32 +: 32], m_regs[k]);
        check("awready", awready_o, e_awr);
        check("wready", wready_o, e_wr);
        check("arready", arready_o, e_arr);
        check("bvalid", bvalid_o, b_q.size() != 0);
        if (b_q.size() != 0) check("bresp", bresp_o, b_q[0]);
        check("rvalid", rvalid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) check("rresp_rdata", {rresp_o, rdata_o}, exp_q[0]);
      end
      if (rst_i) begin
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_aw_q.delete();
        m_w_q.delete();
        b_q.delete();
        exp_q.delete();
        model_live = 1'b1;
      end else if (model_live) begin
        if (exp_q.size() != 0 && rready_i) void'(exp_q.pop_front());
        else if (arvalid_i && e_arr) begin
          hit = decode(araddr_i, idx);
          if (hit) exp_q.push_back({2'b00, m_regs[idx]});
          else     exp_q.push_back({2'b10, 32'h0});
        end
        if (b_q.size() != 0 && bready_i) void'(b_q.pop_front());
        if (awvalid_i && e_awr) m_aw_q.push_back(awaddr_i);
        if (wvalid_i && e_wr) m_w_q.push_back({wstrb_i, wdata_i});
        if (m_aw_q.size() != 0 && m_w_q.size() != 0) begin
          a   = m_aw_q.pop_front();
          w   = m_w_q.pop_front();
          hit = decode(a, idx);
          if (hit) begin
            for (int b = 0; b < 4; b++) if (w[32+b]) m_regs[idx][b*8 +: 8] = w[b*8 +: 8];
          end
          b_q.push_back(hit ? 2'b00 : 2'b10);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // W is offered w_lead cycles before AW; returns just after the commit edge.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int w_lead);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int cyc     = 0;
    wdata_i  = d;
    wstrb_i  = s;
    wvalid_i = 1'b1;
    while (!(aw_done && w_done)) begin
      if (cyc >= w_lead && !aw_done) begin
        awaddr_i  = a;
        awvalid_i = 1'b1;
      end
      @(negedge clk_i);
      if (awvalid_i && awready_o) aw_done = 1'b1;
      if (wvalid_i && wready_o) w_done = 1'b1;
      tick();
      if (aw_done) awvalid_i = 1'b0;
      if (w_done) wvalid_i = 1'b0;
      cyc++;
      if (cyc > 50) begin
        timeout("write_txn");
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        return;
      end
    end
  endtask

  task automatic finish_b();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (bvalid_o && bready_i) begin
        tick();
        return;
      end
      tick();
    end
    timeout("finish_b");
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit done = 1'b0;
    araddr_i  = a;
    arvalid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      done = arready_o;
      tick();
    end
    arvalid_i = 1'b0;
    d = '0;
    r = 2'b11;
    if (!done) begin
      timeout("read_txn");
      return;
    end
    @(negedge clk_i);
    check("read_latency", rvalid_o, 1'b1);
    d = rdata_o;
    r = rresp_o;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic [1:0]  rr;
  logic [31:0] tbl_data [NR];

  initial begin : main
    rst_i = 1'b1;
    awaddr_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    araddr_i = '0; arvalid_i = 1'b0;
    bready_i = 1'b1; rready_i = 1'b1;
    tbl_data[0] = 32'h0101_0101;
    tbl_data[1] = 32'hA5A5_5A5A;
    tbl_data[2] = 32'hFFFF_0000;
    tbl_data[3] = 32'h0000_FFFF;
    tbl_data[4] = 32'h8000_0001;
    repeat (3) tick();

    // Reset: readies low while rst_i is high, outputs cleared.
    @(negedge clk_i);
    check("rst_awready", awready_o, 1'b0);
    check("rst_arready", arready_o, 1'b0);
    check("rst_bvalid", bvalid_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_awready", awready_o, 1'b1);
    check("idle_wready", wready_o, 1'b1);
    check("idle_arready", arready_o, 1'b1);
    check("idle_regs_zero", |regs_o, 1'b0);
    tick();

    // Same-cycle AW+W, then read back.
    write_txn(32'h104, 32'hDEADBEEF, 4'hF, 0);
    @(negedge clk_i);
    check("t2_bvalid", bvalid_o, 1'b1);
    check("t2_bresp", bresp_o, 2'b00);
    tick();
    read_txn(32'h104, rd, rr);
    check("t2_rdata", rd, 32'hDEADBEEF);
    check("t2_rresp", rr, 2'b00);

    // W three cycles ahead of AW, single byte lane over a preloaded value.
    write_txn(32'h100, 32'h11223344, 4'hF, 0);
    finish_b();
    write_txn(32'h100, 32'h000000AA, 4'h1, 3);
    @(negedge clk_i);
    check("t3_bvalid", bvalid_o, 1'b1);
    check("t3_reg0", regs_o[31:0], 32'h112233AA);
    tick();

    // Out-of-range write/read and the low-side miss below BASE.
    write_txn(32'h114, 32'hCAFEF00D, 4'hF, 0);
    @(negedge clk_i);
    check("t4_bvalid", bvalid_o, 1'b1);
    check("t4_bresp", bresp_o, 2'b10);
    check("t4_reg1_kept", regs_o[63:32], 32'hDEADBEEF);
    check("t4_reg4_kept", regs_o[159:128], 32'h0);
    tick();
    read_txn(32'h114, rd, rr);
    check("t4_miss_rdata", rd, 32'h0);
    check("t4_miss_rresp", rr, 2'b10);
    read_txn(32'h0FC, rd, rr);
    check("t4_below_rresp", rr, 2'b10);
    // Top register via an unaligned address, sparse strobes.
    write_txn(32'h113, 32'h12345678, 4'b1010, 0);
    finish_b();
    read_txn(32'h110, rd, rr);
    check("t4_reg4_strb", rd, 32'h12005600);
    check("t4_reg4_rresp", rr, 2'b00);
    write_txn(32'h110, 32'hFFFFFFFF, 4'h0, 1);
    @(negedge clk_i);
    check("t4_nostrb_bresp", bresp_o, 2'b00);
    tick();
    read_txn(32'h110, rd, rr);
    check("t4_nostrb_rdata", rd, 32'h12005600);

    // B back-pressure: response held, AW blocked until the B handshake.
    bready_i = 1'b0;
    write_txn(32'h108, 32'h9, 4'hF, 0);
    awaddr_i  = 32'h10C;
    awvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t5_bvalid_hold", bvalid_o, 1'b1);
      check("t5_bresp_hold", bresp_o, 2'b00);
      check("t5_awready_low", awready_o, 1'b0);
      check("t5_wready_low", wready_o, 1'b0);
      tick();
    end
    bready_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("t5_aw_after_b", awready_o, 1'b1);
    tick();
    awvalid_i = 1'b0;
    wdata_i   = 32'h77;
    wstrb_i   = 4'hF;
    wvalid_i  = 1'b1;
    @(negedge clk_i);
    check("t5_wready", wready_o, 1'b1);
    tick();
    wvalid_i = 1'b0;
    @(negedge clk_i);
    check("t5_bvalid", bvalid_o, 1'b1);
    check("t5_reg3", regs_o[127:96], 32'h77);
    tick();

    // Read and write commit to reg2 on the same edge.
    awaddr_i = 32'h108; awvalid_i = 1'b1;
    wdata_i = 32'h5; wstrb_i = 4'hF; wvalid_i = 1'b1;
    araddr_i = 32'h108; arvalid_i = 1'b1;
    @(negedge clk_i);
    check("t6_all_ready", {awready_o, wready_o, arready_o}, 3'b111);
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    @(negedge clk_i);
    check("t6_old_value", rdata_o, 32'h9);
    check("t6_bvalid", bvalid_o, 1'b1);
    check("t6_reg2_new", regs_o[95:64], 32'h5);
    tick();
    read_txn(32'h108, rd, rr);
    check("t6_new_value", rd, 32'h5);

    // Fill every register with a different W lead, then read all back.
    for (int i = 0; i < NR; i++) begin
      write_txn(BASE + 32'(i * 4), tbl_data[i], 4'hF, i % 3);
      finish_b();
    end
    for (int i = 0; i < NR; i++) begin
      read_txn(BASE + 32'(i * 4), rd, rr);
      check("tbl_rdata", rd, tbl_data[i]);
    end

    // Reset while both B and R are pending.
    bready_i = 1'b0;
    rready_i = 1'b0;
    write_txn(32'h100, 32'hABCD, 4'hF, 0);
    araddr_i  = 32'h104;
    arvalid_i = 1'b1;
    tick();
    arvalid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t7_pending_b", bvalid_o, 1'b1);
    check("t7_rst_arready", arready_o, 1'b0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t7_bvalid_drop", bvalid_o, 1'b0);
    check("t7_rvalid_drop", rvalid_o, 1'b0);
    check("t7_rdata_clear", rdata_o, 32'h0);
    check("t7_regs_clear", |regs_o, 1'b0);
    tick();
    bready_i = 1'b1;
    rready_i = 1'b1;
    read_txn(32'h100, rd, rr);
    check("t7_reg0_zero", rd, 32'h0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder (slave) endpoint that terminates one crossbar master port with a bank of NUM_REGS software-visible registers.
- Accepts AW/W/AR, performs byte-strobed writes and single-beat reads, and returns B/R responses.
- Out-of-range accesses return SLVERR.
- Serves as the standard leaf target for crossbar integration and verification. Register widths are derived with idx_width from axi_math_pkg.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 8, number of registers; must be ≥1. Need not be a power of 2.
- BASE_ADDR, 0, byte base address; aligned to next_pow2(NUM_REGS)*DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- awaddr_i  in  ADDR_WIDTH  write address.
- awvalid_i  in  1  AW valid.
- awready_o  out  1  AW ready.
- wdata_i  in  DATA_WIDTH  write data.
- wstrb_i  in  DATA_WIDTH/8  byte strobes.
- wvalid_i  in  1  W valid.
- wready_o  out  1  W ready.
- bresp_o  out  2  write response.
- bvalid_o  out  1  B valid.
- bready_i  in  1  B ready.
- araddr_i  in  ADDR_WIDTH  read address.
- arvalid_i  in  1  AR valid.
- arready_o  out  1  AR ready.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response.
- rvalid_o  out  1  R valid.
- rready_i  in  1  R ready.
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (synchronous, rst_i=1 at clock edge):
  - all registers cleared to 0; internal AW/W holding flags cleared.
  - bvalid_o=0, rvalid_o=0, bresp_o=0, rresp_o=0, rdata_o=0.
  - Readies are combinational and read 0 while rst_i=1. Reset mid-transaction drops any held or pending response.
- Address decode:
  - off = addr - BASE_ADDR.
  - idx = off >> $clog2(DATA_WIDTH/8).
  - Hit iff addr >= BASE_ADDR and idx < NUM_REGS. Low byte-offset bits are ignored.
  - Index register width is idx_width(NUM_REGS).
- Write path, with AW and W captured independently:
  - awready_o = !aw_held && !bvalid_o; wready_o = !w_held && !bvalid_o.
  - A handshake sets the respective held flag and latches addr, or data plus strobe.
  - AW and W may arrive in the same cycle or in either order.
  - Commit cycle is the first edge at which both are held, counting same-cycle handshakes as held.
    - On a hit, apply byte lanes with strobe set and set bresp_o=2'b00 (OKAY).
    - On a miss, no register changes and bresp_o=2'b10 (SLVERR).
    - bvalid_o rises on that same edge, so latency is 1 cycle from the later of the AW/W handshakes to bvalid_o. The held flags clear.
  - bvalid_o and bresp_o stay stable until bready_i. No new AW/W is accepted while bvalid_o=1.
  - Throughput: one write per 2 cycles minimum.
  - wstrb_i=0 on a hit → OKAY, no change.
- Read path:
  - arready_o = !rvalid_o.
  - On the AR handshake edge:
    - hit: rdata_o = reg[idx], rresp_o = OKAY.
    - miss: rdata_o = 0, rresp_o = SLVERR.
    - rvalid_o = 1.
  - Latency is 1 cycle. rdata_o and rresp_o stay stable until rready_i.
  - Throughput: one read per 2 cycles.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value. The new value is visible to an AR accepted on any later edge.
- Read and write paths are fully independent and may proceed in the same cycle.
- regs_o reflects register state after each edge, with no extra latency.

Decomposition:
- Shared package axi_pkg, imported alongside axi_math_pkg:
  - resp type axi_resp_t (2 bits).
  - constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Width helpers idx_width and next_pow2 come from axi_math_pkg; no new math functions.
- One sub-module: axi_lite_regfile.
  - NUM_REGS×DATA_WIDTH storage with one byte-strobed write port and one combinational read port.
  - Also drives regs_o.
- Handshake control stays in the top module.

Test Plan:
1. Reset then idle → all outputs 0; awready_o=wready_o=arready_o=1 one cycle after rst_i falls; regs_o=0.
2. Same-cycle AW(0x4)+W(0xDEADBEEF, strb 0xF) with bready_i=1 → bvalid_o=1 next cycle with OKAY; then AR(0x4) → rdata_o=0xDEADBEEF with OKAY, 1 cycle after the AR handshake.
3. W (0x000000AA, strb 0x1) three cycles before AW(0x0); then AW(0x0) with reg0 preloaded to 0x11223344 → bvalid_o 1 cycle after the AW handshake; reg0 = 0x112233AA.
4. With NUM_REGS=5: AW(0x14)+W → SLVERR and regs_o unchanged; AR(0x14) → rdata_o=0 with SLVERR; AR(BASE_ADDR-4) with BASE_ADDR=0x100 → SLVERR.
5. bready_i=0 for 4 cycles after a write → bvalid_o and bresp_o held stable; awready_o=wready_o=0 throughout; a pending AW is accepted only after the B handshake.
6. Write commit of 0x5 to reg2 (old value 0x9) on the same edge as an AR(0x8) handshake → read returns 0x9; the next AR(0x8) returns 0x5. Separately, asserting rst_i while bvalid_o=1 → bvalid_o=0 on the next edge and all registers read 0.
